// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and majority helper shared by the UART RX blocks
package uart_rx_pkg;
  localparam int PRESCALE_W = 6;
  localparam logic RX_IDLE_LEVEL = 1'b1;
  localparam int PRESC_8 = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep synchroniser for an asynchronous line, resets to idle level
import uart_rx_pkg::*;
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_chain <= {STAGES{RX_IDLE_LEVEL}};
    else r_chain <= {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/data_sampling.sv
// data_sampling: 3-point mid-bit majority sampler for UART RX.
// Optional noise_flag output enabled by DATA_SAMP_NOISE_FLAG_EN.
import uart_rx_pkg::*;
module data_sampling #(
  parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
`ifdef DATA_SAMP_NOISE_FLAG_EN
  output logic                  noise_flag,
`endif
  output logic                  sampled_bit,
  output logic                  sample_valid
);
  logic                  w_rx_s;
  logic [PRESCALE_W-1:0] w_half;
  logic                  w_ok;
  logic                  w_dec;
  logic [2:0]            r_s;
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.CLK(CLK), .RST(RST), .i_d(RX_IN), .o_q(w_rx_s));
  assign w_half = Prescale >> 1;
  assign w_ok   = (Prescale >= PRESCALE_W'(8)) && !Prescale[0];
  assign w_dec  = dat_samp_en && w_ok && (edge_cnt == w_half + PRESCALE_W'(1));
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_s          <= '1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
`ifdef DATA_SAMP_NOISE_FLAG_EN
      noise_flag   <= 1'b0;
`endif
    end else begin
      sample_valid <= w_dec;
      if (!dat_samp_en) r_s <= '1;
      else if (w_ok) begin
        if (edge_cnt == w_half - PRESCALE_W'(2)) r_s[0] <= w_rx_s;
        if (edge_cnt == w_half - PRESCALE_W'(1)) r_s[1] <= w_rx_s;
        if (edge_cnt == w_half) r_s[2] <= w_rx_s;
      end
      if (w_dec) sampled_bit <= maj3(r_s[0], r_s[1], r_s[2]);
`ifdef DATA_SAMP_NOISE_FLAG_EN
      if (!dat_samp_en) noise_flag <= 1'b0;
      else if (w_dec) noise_flag <= !(&r_s) && (|r_s);
`endif
    end
endmodule

// File: doc/data_sampling.md
Name: data_sampling

Overview:
- Upstream neighbour of the UART RX start/parity/stop checkers; produces the `sampled_bit` they consume.
- Synchronises the asynchronous serial line into the RX clock domain.
- Takes three oversampled values around mid-bit and majority-votes them into one decided bit per bit period.
- Emits a one-cycle `sample_valid` strobe when each decided bit is ready.

Parameters:
- PRESCALE_W, 6, width of the Prescale and edge_cnt buses.
- SYNC_STAGES, 2, number of flip-flops in the RX_IN synchroniser (legal values ≥2).

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  raw serial line; idle high; asynchronous to CLK.
- dat_samp_en  input  1  sampling enable from the RX FSM.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- edge_cnt  input  PRESCALE_W  current edge index within the bit period, 0..Prescale-1, from the edge/bit counter.
- sampled_bit  output  1  majority-voted bit value.
- sample_valid  output  1  one-cycle strobe: sampled_bit was updated this cycle.

Behaviour:
- Reset (RST low, asynchronous):
  - all synchroniser flops = 1
  - s0, s1, s2 = 1
  - sampled_bit = 1
  - sample_valid = 0
- Synchroniser:
  - rx_s = RX_IN delayed by SYNC_STAGES CLK cycles.
  - All sampling uses rx_s only; RX_IN is never used elsewhere.
- Sample points (half = Prescale>>1):
  - s0 captured when edge_cnt == half-2
  - s1 captured when edge_cnt == half-1
  - s2 captured when edge_cnt == half
  - Example, Prescale=8: edges 2, 3, 4.
- Decision edge, at edge_cnt == half+1 with dat_samp_en=1:
  - sampled_bit <= (s0&s1)|(s0&s2)|(s1&s2)
  - sample_valid = 1 for exactly that cycle; 0 otherwise.
- Latency:
  - sampled_bit is valid one cycle after the decision edge (registered output).
  - The checkers sample it on or after the cycle in which sample_valid is high.
- dat_samp_en = 0:
  - s0, s1, s2 reload 1 every cycle.
  - sample_valid = 0.
  - sampled_bit holds its last value.
- Enable drops mid-bit: partial samples are discarded; the next bit restarts from s0=s1=s2=1.
- Illegal Prescale (< 8 or odd):
  - No capture, no decision.
  - sample_valid stays 0; sampled_bit holds.
- Prescale change is only allowed while dat_samp_en=0. A change with enable high gives undefined sample placement but must not hang; the block stays stateless beyond s0, s1, s2.
- Simultaneous capture and decision cannot occur for legal Prescale (distinct edge indices).
- edge_cnt wrap from Prescale-1 to 0 needs no special handling.
- Synchroniser latency is constant; the FSM/edge counter owns alignment. Start detection is done on rx_s (exported via the same sync sub-module).

Optional Feature:
- Macro: DATA_SAMP_NOISE_FLAG_EN.
- Defined:
  - Extra output port noise_flag (1 bit, reset 0).
  - noise_flag is registered alongside sampled_bit at the decision edge.
  - Value = 1 when s0, s1, s2 are not all equal; 0 when unanimous.
  - It holds its value between decisions and clears when dat_samp_en=0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package uart_rx_pkg:
  - PRESCALE_W
  - RX_IDLE_LEVEL = 1'b1
  - legal prescale constants PRESC_8/16/32
  - function maj3
- Sub-module bit_sync: SYNC_STAGES-deep flop chain, reset to RX_IDLE_LEVEL, same CLK/RST.

Test Plan:
1. Reset: RST=0 with RX_IN=0 -> sampled_bit=1, sample_valid=0, noise_flag=0; after release with en=0 for 20 cycles, outputs unchanged.
2. Clean bit, Prescale=8: RX_IN held 0 across a full bit, edge_cnt sweeping 0..7, en=1 -> sample_valid pulses once, at edge_cnt=5; sampled_bit=0; noise_flag=0.
3. Glitch rejection, Prescale=16: line 1, but rx_s=0 only at edge 7 -> samples 1,0,1 -> sampled_bit=1; noise_flag=1.
4. Majority low, Prescale=32: rx_s=0 at edges 14 and 15, 1 at edge 16 -> sampled_bit=0, sample_valid at edge 17.
5. Enable drop: en=1 through edge 3 (Prescale=8), en=0 at edge 4 -> no sample_valid; sampled_bit holds previous value; next enabled bit decides correctly.
6. Illegal Prescale=6 with en=1 for 3 bit periods -> sample_valid never asserted; mid-operation async reset -> all outputs return to reset values immediately.
